// File: rtl/oam_dma.sv
// oam_dma: sprite-memory DMA engine.
// A CPU write to 16'h4014 starts a transfer. The CPU is stalled while the
// 256 bytes of page {cpu_dout, 8'h00}..{cpu_dout, 8'hFF} are copied to 16'h2004,
// one read/write pair per byte.
// Optional feature macro: OAM_DMA_ALIGN_EN. When it is defined, a parity
// flop adds a single ALIGN cycle after HALT on even-parity triggers.
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_aout,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mr,
  input  logic        cpu_mw,
  input  logic [7:0]  din,
  output logic [15:0] aout,
  output logic [7:0]  dout,
  output logic        mr,
  output logic        mw,
  output logic        cpu_pause,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data;
  logic        trigger;

`ifdef OAM_DMA_ALIGN_EN
  logic        parity;
`endif

  // A trigger can only come from the CPU's own write while the engine is idle.
  assign trigger = (state == IDLE) && cpu_mw && (cpu_aout == 16'h4014);

  // Transfer sequencer: advances only on ce; the reset is synchronous and ignores ce.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      data   <= 8'h00;
`ifdef OAM_DMA_ALIGN_EN
      parity <= 1'b0;
`endif
    end else if (ce) begin
`ifdef OAM_DMA_ALIGN_EN
      parity <= ~parity;
`endif
      case (state)
        IDLE: begin
          if (trigger) begin
            page  <= cpu_dout;
            idx   <= 8'h00;
            state <= HALT;
          end
        end
        HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          state <= parity ? ALIGN : READ;
`else
          state <= READ;
`endif
        end
        ALIGN: state <= READ;
        READ: begin
          data  <= din;
          state <= WRITE;
        end
        WRITE: begin
          idx   <= idx + 8'd1;
          state <= (idx == 8'hFF) ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus mux: the CPU owns the bus while idle; otherwise the DMA drives it.
  always_comb begin
    aout      = cpu_aout;
    dout      = cpu_dout;
    mr        = cpu_mr;
    mw        = cpu_mw;
    cpu_pause = 1'b1;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cpu_pause = 1'b0;
        busy      = 1'b0;
      end
      HALT, ALIGN: begin
        aout = 16'h0000;
        dout = 8'h00;
        mr   = 1'b0;
        mw   = 1'b0;
      end
      READ: begin
        aout = {page, idx};
        dout = 8'h00;
        mr   = 1'b1;
        mw   = 1'b0;
      end
      WRITE: begin
        aout = 16'h2004;
        dout = data;
        mr   = 1'b0;
        mw   = 1'b1;
      end
      default: begin
        cpu_pause = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
REQ-003 SHALL have port: ce  input  1  clock enable; state advances only when ce=1.
REQ-004 SHALL have port: cpu_aout  input  16  CPU address bus.
REQ-005 SHALL have port: cpu_dout  input  8  CPU write data.
REQ-006 SHALL have port: cpu_mr  input  1  CPU read strobe.
REQ-007 SHALL have port: cpu_mw  input  1  CPU write strobe.
REQ-008 SHALL have port: din  input  8  memory read data, valid in the same ce cycle as aout.
REQ-009 SHALL have port: aout  output  16  system address bus.
REQ-010 SHALL have port: dout  output  8  system write data.
REQ-011 SHALL have port: mr  output  1  system read strobe.
REQ-012 SHALL have port: mw  output  1  system write strobe.
REQ-013 SHALL have port: cpu_pause  output  1  CPU stall; the CPU clock enable is ce & ~cpu_pause.
REQ-014 SHALL have port: busy  output  1  DMA transfer in progress.

Function
REQ-015 SHALL use states IDLE, HALT, ALIGN, READ, WRITE.
REQ-016 SHALL, in IDLE, pass cpu_aout/cpu_dout/cpu_mr/cpu_mw through combinationally to aout/dout/mr/mw, with cpu_pause=0 and busy=0.
REQ-017 SHALL detect a trigger when ce=1, state=IDLE, cpu_mw=1 and cpu_aout=16'h4014.
REQ-018 SHALL, on a trigger, latch cpu_dout as page[7:0], clear idx[7:0] to 0, and enter HALT; the trigger write itself completes as passthrough.
REQ-019 SHALL assert cpu_pause=1 and busy=1 in every state other than IDLE.
REQ-020 SHALL, in HALT and ALIGN, drive mr=0, mw=0, aout=16'h0000 and dout=0 for exactly one ce cycle each.
REQ-021 SHALL maintain a parity flop that toggles on every ce=1 cycle; it is 0 in the first ce cycle after reset.
REQ-022 SHALL leave HALT for READ if the next cycle's parity is even, otherwise for ALIGN; ALIGN always goes to READ.
REQ-023 SHALL, in READ, drive aout={page,idx}, mr=1, mw=0, latch din into data[7:0] at the ce edge, and go to WRITE.
REQ-024 SHALL, in WRITE, drive aout=16'h2004, dout=data, mw=1, mr=0; at the ce edge it increments idx (mod 256) and goes to READ, or to IDLE when idx was 8'hFF.
REQ-025 SHALL pause the CPU for exactly 513 ce cycles when the trigger occurs on an odd-parity cycle and 514 when it occurs on an even-parity cycle (HALT + optional ALIGN + 256 READ/WRITE pairs).
REQ-026 SHALL restore passthrough and drop cpu_pause combinationally in the cycle after the final WRITE.
REQ-027 SHALL ignore writes to 16'h4014 while not IDLE.
REQ-028 SHALL hold all state, idx, data and parity when ce=0; outputs remain those of the current state.
REQ-029 SHALL treat page values 8'h20 and 8'h40 like any other page, with no address filtering.

Reset
REQ-030 SHALL, when reset=0 at a clk edge regardless of ce, enter IDLE with page=0, idx=0, data=0 and parity=0, aborting any transfer in progress.
REQ-031 SHALL, during and after reset, drive cpu_pause=0 and busy=0 with passthrough active.

Configuration
REQ-032 SHALL, with macro OAM_DMA_ALIGN_EN defined, implement the parity flop, the ALIGN state and the 513/514-cycle behaviour of REQ-021/022/025.
REQ-033 SHALL, without OAM_DMA_ALIGN_EN, omit the parity flop and ALIGN: HALT always goes to READ and every transfer pauses the CPU for exactly 513 cycles.

Verification
REQ-034 SHALL cover: with ALIGN_EN, write 8'h02 to 16'h4014 on parity-1 cycle, memory 16'h0200+i=i^8'h5A -> 256 writes to 16'h2004 with data i^8'h5A in order, cpu_pause high for 513 cycles.
REQ-035 SHALL cover: same stimulus on a parity-0 cycle -> one ALIGN cycle (mr=mw=0) after HALT, cpu_pause high for 514 cycles.
REQ-036 SHALL cover: ce toggling 1,0,0,1 throughout a page-8'h03 transfer -> identical address/data sequence and a 513/514 ce-cycle count; nothing advances while ce=0.
REQ-037 SHALL cover: reset=0 asserted in WRITE with idx=8'h80 -> next cycle IDLE, cpu_pause=0, passthrough; a new 16'h4014 write restarts from idx=0.
REQ-038 SHALL cover: a CPU read of 16'h4014 and a write to 16'h4015 while IDLE -> no trigger, busy stays 0.
REQ-039 SHALL cover: without OAM_DMA_ALIGN_EN, triggers on both parities -> cpu_pause high for exactly 513 cycles each time.
